// File: rtl/recepcao_comandos_servo_if.sv
// Bundle between the serial receiver, the command-frame parser and the servo
// controllers. The parser sits on the slave side; whoever feeds characters
// (receiver or bench) holds the master side.
//
// Handshake: pronto_rx is a one-cycle strobe with no back-pressure. dado_rx is
// meaningful only in a cycle where pronto_rx=1, and the parser consumes that
// character on the rising clock edge that ends the cycle. The sender never
// waits for any acknowledgement.
interface recepcao_comandos_servo_if;
  logic [6:0] dado_rx;
  logic       pronto_rx;
  logic [1:0] posicao_1;
  logic [1:0] posicao_2;
  logic [1:0] posicao_3;
  logic       novo_comando;
  logic       erro_quadro;
  logic [7:0] db_num_erros;
  logic [3:0] db_estado;

  modport master (
    output dado_rx, pronto_rx,
    input  posicao_1, posicao_2, posicao_3,
    input  novo_comando, erro_quadro, db_num_erros, db_estado
  );

  modport slave (
    input  dado_rx, pronto_rx,
    output posicao_1, posicao_2, posicao_3,
    output novo_comando, erro_quadro, db_num_erros, db_estado
  );
endinterface

// File: rtl/recepcao_comandos_servo.sv
// Command-frame parser: accepts "#D1D2D3." one character per pronto_rx strobe,
// collects the three digits in shadow registers and commits them to the servo
// positions in one edge. Malformed or stalled frames are dropped and counted.
module recepcao_comandos_servo #(
  parameter int TIMEOUT      = 5_000_000,
  parameter int TIMEOUT_BITS = 23
) (
  input  logic                      clock,
  input  logic                      reset,
  recepcao_comandos_servo_if.slave  bus
);

  typedef enum logic [3:0] {
    ESPERA_INICIO = 4'h0,
    RECEBE_1      = 4'h1,
    RECEBE_2      = 4'h2,
    RECEBE_3      = 4'h3,
    ESPERA_FIM    = 4'h4,
    ATUALIZA      = 4'h5,
    ERRO          = 4'hE
  } estado_t;

  localparam logic [6:0]              CHAR_INICIO = 7'h23;
  localparam logic [6:0]              CHAR_FIM    = 7'h2E;
  localparam logic [TIMEOUT_BITS-1:0] LIMITE      = TIMEOUT_BITS'(TIMEOUT - 1);

  estado_t                 estado;
  estado_t                 proximo;
  logic [1:0]              sombra_1;
  logic [1:0]              sombra_2;
  logic [1:0]              sombra_3;
  logic [1:0]              posicao_1;
  logic [1:0]              posicao_2;
  logic [1:0]              posicao_3;
  logic [7:0]              num_erros;
  logic [TIMEOUT_BITS-1:0] contador;

  logic e_digito;
  logic e_inicio;
  logic e_fim;
  logic em_quadro;
  logic expirou;
  logic carrega_1;
  logic carrega_2;
  logic carrega_3;
  logic limpa_sombras;
  logic carrega_posicoes;

  // Character classification and inter-character timeout detection.
  always_comb begin
    e_digito  = (bus.dado_rx[6:2] == 5'b01100);
    e_inicio  = (bus.dado_rx == CHAR_INICIO);
    e_fim     = (bus.dado_rx == CHAR_FIM);
    em_quadro = (estado == RECEBE_1) || (estado == RECEBE_2) ||
                (estado == RECEBE_3) || (estado == ESPERA_FIM);
    // A strobe in the expiry cycle wins: the character is processed instead.
    expirou   = em_quadro && !bus.pronto_rx && (contador == LIMITE);
  end

  // Next-state decode plus the datapath load strobes that go with each move.
  always_comb begin
    proximo          = estado;
    carrega_1        = 1'b0;
    carrega_2        = 1'b0;
    carrega_3        = 1'b0;
    limpa_sombras    = 1'b0;
    carrega_posicoes = 1'b0;
    case (estado)
      ESPERA_INICIO: begin
        if (bus.pronto_rx && e_inicio) begin
          proximo       = RECEBE_1;
          limpa_sombras = 1'b1;
        end
      end
      RECEBE_1, RECEBE_2, RECEBE_3: begin
        if (expirou) begin
          proximo = ERRO;
        end else if (bus.pronto_rx) begin
          if (e_digito) begin
            case (estado)
              RECEBE_1: begin proximo = RECEBE_2;   carrega_1 = 1'b1; end
              RECEBE_2: begin proximo = RECEBE_3;   carrega_2 = 1'b1; end
              default:  begin proximo = ESPERA_FIM; carrega_3 = 1'b1; end
            endcase
          end else if (e_inicio) begin
            proximo       = RECEBE_1;
            limpa_sombras = 1'b1;
          end else begin
            proximo = ERRO;
          end
        end
      end
      ESPERA_FIM: begin
        if (expirou) begin
          proximo = ERRO;
        end else if (bus.pronto_rx) begin
          if (e_fim) begin
            proximo          = ATUALIZA;
            carrega_posicoes = 1'b1;
          end else if (e_inicio) begin
            proximo       = RECEBE_1;
            limpa_sombras = 1'b1;
          end else begin
            proximo = ERRO;
          end
        end
      end
      ATUALIZA: proximo = ESPERA_INICIO;
      ERRO:     proximo = ESPERA_INICIO;
      default:  proximo = ESPERA_INICIO;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= ESPERA_INICIO;
    else        estado <= proximo;
  end

  // Shadow digits: cleared on every frame (re)start, loaded one per digit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sombra_1 <= 2'b00;
      sombra_2 <= 2'b00;
      sombra_3 <= 2'b00;
    end else if (limpa_sombras) begin
      sombra_1 <= 2'b00;
      sombra_2 <= 2'b00;
      sombra_3 <= 2'b00;
    end else begin
      if (carrega_1) sombra_1 <= bus.dado_rx[1:0];
      if (carrega_2) sombra_2 <= bus.dado_rx[1:0];
      if (carrega_3) sombra_3 <= bus.dado_rx[1:0];
    end
  end

  // Servo positions: all three committed together when the frame terminator arrives.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      posicao_1 <= 2'b00;
      posicao_2 <= 2'b00;
      posicao_3 <= 2'b00;
    end else if (carrega_posicoes) begin
      posicao_1 <= sombra_1;
      posicao_2 <= sombra_2;
      posicao_3 <= sombra_3;
    end
  end

  // Inter-character timer: runs only inside a frame, restarts on each strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                 contador <= '0;
    else if (!em_quadro || bus.pronto_rx || expirou) contador <= '0;
    else                                        contador <= contador + 1'b1;
  end

  // Discarded-frame counter, saturating at 255, stepped while in ERRO.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                   num_erros <= 8'd0;
    else if ((estado == ERRO) && (num_erros != 8'hFF)) num_erros <= num_erros + 8'd1;
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    bus.novo_comando = (estado == ATUALIZA);
    bus.erro_quadro  = (estado == ERRO);
    bus.db_estado    = estado;
    bus.db_num_erros = num_erros;
    bus.posicao_1    = posicao_1;
    bus.posicao_2    = posicao_2;
    bus.posicao_3    = posicao_3;
  end

endmodule

// File: tb/tb_recepcao_comandos_servo.sv
// Directed bench for the servo command-frame parser (TIMEOUT shortened to 20).
module tb_recepcao_comandos_servo;

  logic clock;
  logic reset;

  recepcao_comandos_servo_if bus ();

  recepcao_comandos_servo #(
    .TIMEOUT      (20),
    .TIMEOUT_BITS (5)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int exp_err  = 0;
  int nov_cnt  = 0;
  int err_cnt  = 0;

  logic [5:0] exp_q[$];

  // Clock and watchdog.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: each novo_comando pulse must match the next expected position set.
  always @(negedge clock) begin
    if (bus.erro_quadro) err_cnt++;
    if (bus.novo_comando) begin
      nov_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_update: got %b expected no update",
                 {bus.posicao_1, bus.posicao_2, bus.posicao_3});
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        if ({bus.posicao_1, bus.posicao_2, bus.posicao_3} !== e) begin
          failures++;
          $display("FAIL sb_positions: got %b expected %b",
                   {bus.posicao_1, bus.posicao_2, bus.posicao_3}, e);
        end
      end
    end
  end

  // Driver: strobe one character; the consuming edge is the next posedge and
  // the task returns at the negedge after it.
  task automatic send_char(input logic [6:0] c);
    bus.dado_rx   = c;
    bus.pronto_rx = 1'b1;
    @(negedge clock);
    bus.pronto_rx = 1'b0;
    bus.dado_rx   = 7'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    bus.pronto_rx = 1'b0;
    bus.dado_rx   = 7'h00;
    idle(2);
    checks++;
    if ({bus.posicao_1, bus.posicao_2, bus.posicao_3} !== 6'b000000) begin
      failures++; $display("FAIL reset_positions: got %b expected 000000",
                           {bus.posicao_1, bus.posicao_2, bus.posicao_3}); end
    checks++;
    if ({bus.novo_comando, bus.erro_quadro} !== 2'b00) begin
      failures++; $display("FAIL reset_pulses: got %b expected 00",
                           {bus.novo_comando, bus.erro_quadro}); end
    checks++;
    if (bus.db_num_erros !== 8'd0) begin
      failures++; $display("FAIL reset_num_erros: got %0d expected 0", bus.db_num_erros); end
    reset = 1'b1;
    idle(1);
    checks++;
    if (bus.db_estado !== 4'h0) begin
      failures++; $display("FAIL reset_estado: got %0h expected 0", bus.db_estado); end
  endtask

  task automatic test_valid_frame();
    int n0, e0;
    n0 = nov_cnt; e0 = err_cnt;
    send_char(7'h23);
    checks++;
    if (bus.db_estado !== 4'h1) begin
      failures++; $display("FAIL frame_estado_r1: got %0h expected 1", bus.db_estado); end
    idle(11); send_char(7'h31);
    checks++;
    if (bus.db_estado !== 4'h2) begin
      failures++; $display("FAIL frame_estado_r2: got %0h expected 2", bus.db_estado); end
    idle(11); send_char(7'h32);
    idle(11); send_char(7'h33);
    checks++;
    if (bus.db_estado !== 4'h4) begin
      failures++; $display("FAIL frame_estado_fim: got %0h expected 4", bus.db_estado); end
    checks++;
    if ({bus.posicao_1, bus.posicao_2, bus.posicao_3} !== 6'b000000) begin
      failures++; $display("FAIL frame_no_partial: got %b expected 000000",
                           {bus.posicao_1, bus.posicao_2, bus.posicao_3}); end
    idle(11);
    exp_q.push_back(6'b01_10_11);
    send_char(7'h2E);
    checks++;
    if ({bus.posicao_1, bus.posicao_2, bus.posicao_3} !== 6'b011011) begin
      failures++; $display("FAIL frame_positions: got %b expected 011011",
                           {bus.posicao_1, bus.posicao_2, bus.posicao_3}); end
    checks++;
    if ({bus.novo_comando, bus.db_estado} !== 5'b1_0101) begin
      failures++; $display("FAIL frame_atualiza: got %b expected 10101",
                           {bus.novo_comando, bus.db_estado}); end
    idle(1);
    checks++;
    if ({bus.novo_comando, bus.db_estado} !== 5'b0_0000) begin
      failures++; $display("FAIL frame_back_idle: got %b expected 00000",
                           {bus.novo_comando, bus.db_estado}); end
    checks++;
    if ((nov_cnt - n0) !== 1 || (err_cnt - e0) !== 0) begin
      failures++; $display("FAIL frame_pulse_counts: got nov=%0d err=%0d expected nov=1 err=0",
                           nov_cnt - n0, err_cnt - e0); end
  endtask

  task automatic test_bad_digit();
    send_char(7'h23); idle(11);
    send_char(7'h31); idle(11);
    send_char(7'h37);
    checks++;
    if ({bus.erro_quadro, bus.db_estado} !== 5'b1_1110) begin
      failures++; $display("FAIL bad_digit_erro: got %b expected 11110",
                           {bus.erro_quadro, bus.db_estado}); end
    checks++;
    if (bus.db_num_erros !== 8'(exp_err)) begin
      failures++; $display("FAIL bad_digit_count_early: got %0d expected %0d",
                           bus.db_num_erros, exp_err); end
    idle(1);
    exp_err++;
    checks++;
    if (bus.db_num_erros !== 8'(exp_err)) begin
      failures++; $display("FAIL bad_digit_count: got %0d expected %0d", bus.db_num_erros, exp_err); end
    checks++;
    if ({bus.erro_quadro, bus.db_estado} !== 5'b0_0000) begin
      failures++; $display("FAIL bad_digit_idle: got %b expected 00000",
                           {bus.erro_quadro, bus.db_estado}); end
    checks++;
    if ({bus.posicao_1, bus.posicao_2, bus.posicao_3} !== 6'b011011) begin
      failures++; $display("FAIL bad_digit_hold: got %b expected 011011",
                           {bus.posicao_1, bus.posicao_2, bus.posicao_3}); end
    send_char(7'h23); idle(2);
    send_char(7'h33); idle(2);
    send_char(7'h30); idle(2);
    send_char(7'h32); idle(2);
    exp_q.push_back(6'b11_00_10);
    send_char(7'h2E);
    checks++;
    if ({bus.posicao_1, bus.posicao_2, bus.posicao_3} !== 6'b110010) begin
      failures++; $display("FAIL bad_digit_next_frame: got %b expected 110010",
                           {bus.posicao_1, bus.posicao_2, bus.posicao_3}); end
    idle(1);
  endtask

  task automatic test_resync();
    int e0;
    e0 = err_cnt;
    send_char(7'h23); idle(2);
    send_char(7'h32);
    checks++;
    if (bus.db_estado !== 4'h2) begin
      failures++; $display("FAIL resync_r2: got %0h expected 2", bus.db_estado); end
    idle(2);
    send_char(7'h23);
    checks++;
    if (bus.db_estado !== 4'h1) begin
      failures++; $display("FAIL resync_restart: got %0h expected 1", bus.db_estado); end
    idle(2); send_char(7'h30);
    idle(2); send_char(7'h31);
    idle(2); send_char(7'h33);
    idle(2);
    exp_q.push_back(6'b00_01_11);
    send_char(7'h2E);
    checks++;
    if ({bus.posicao_1, bus.posicao_2, bus.posicao_3} !== 6'b000111) begin
      failures++; $display("FAIL resync_positions: got %b expected 000111",
                           {bus.posicao_1, bus.posicao_2, bus.posicao_3}); end
    idle(1);
    checks++;
    if ((err_cnt - e0) !== 0 || bus.db_num_erros !== 8'(exp_err)) begin
      failures++; $display("FAIL resync_no_error: got pulses=%0d count=%0d expected pulses=0 count=%0d",
                           err_cnt - e0, bus.db_num_erros, exp_err); end
  endtask

  task automatic test_timeout();
    send_char(7'h23); idle(2);
    send_char(7'h31);
    idle(19);
    checks++;
    if ({bus.erro_quadro, bus.db_estado} !== 5'b0_0010) begin
      failures++; $display("FAIL timeout_early: got %b expected 00010",
                           {bus.erro_quadro, bus.db_estado}); end
    idle(1);
    checks++;
    if ({bus.erro_quadro, bus.db_estado} !== 5'b1_1110) begin
      failures++; $display("FAIL timeout_erro: got %b expected 11110",
                           {bus.erro_quadro, bus.db_estado}); end
    idle(1);
    exp_err++;
    checks++;
    if (bus.db_num_erros !== 8'(exp_err)) begin
      failures++; $display("FAIL timeout_count: got %0d expected %0d", bus.db_num_erros, exp_err); end
    send_char(7'h23); idle(2);
    send_char(7'h31);
    idle(19);
    checks++;
    if (bus.db_estado !== 4'h2) begin
      failures++; $display("FAIL timeout_last_cycle_wait: got %0h expected 2", bus.db_estado); end
    send_char(7'h32);
    checks++;
    if ({bus.erro_quadro, bus.db_estado} !== 5'b0_0011) begin
      failures++; $display("FAIL timeout_last_cycle_char: got %b expected 00011",
                           {bus.erro_quadro, bus.db_estado}); end
    idle(2); send_char(7'h33);
    idle(2);
    exp_q.push_back(6'b01_10_11);
    send_char(7'h2E);
    checks++;
    if ({bus.posicao_1, bus.posicao_2, bus.posicao_3} !== 6'b011011) begin
      failures++; $display("FAIL timeout_recovered_frame: got %b expected 011011",
                           {bus.posicao_1, bus.posicao_2, bus.posicao_3}); end
    idle(1);
  endtask

  task automatic test_garbage();
    int n0, e0;
    n0 = nov_cnt; e0 = err_cnt;
    send_char(7'h41);
    checks++;
    if (bus.db_estado !== 4'h0) begin
      failures++; $display("FAIL garbage_A: got %0h expected 0", bus.db_estado); end
    idle(2); send_char(7'h2E);
    checks++;
    if (bus.db_estado !== 4'h0) begin
      failures++; $display("FAIL garbage_dot: got %0h expected 0", bus.db_estado); end
    idle(2); send_char(7'h35);
    checks++;
    if (bus.db_estado !== 4'h0) begin
      failures++; $display("FAIL garbage_5: got %0h expected 0", bus.db_estado); end
    idle(2);
    checks++;
    if ((nov_cnt - n0) !== 0 || (err_cnt - e0) !== 0 || bus.db_num_erros !== 8'(exp_err)) begin
      failures++; $display("FAIL garbage_quiet: got nov=%0d err=%0d count=%0d expected 0 0 %0d",
                           nov_cnt - n0, err_cnt - e0, bus.db_num_erros, exp_err); end
  endtask

  task automatic test_saturation();
    while (exp_err < 255) begin
      send_char(7'h23);
      send_char(7'h5A);
      idle(1);
      exp_err++;
    end
    checks++;
    if (bus.db_num_erros !== 8'd255) begin
      failures++; $display("FAIL sat_reach: got %0d expected 255", bus.db_num_erros); end
    send_char(7'h23);
    send_char(7'h5A);
    checks++;
    if (bus.erro_quadro !== 1'b1) begin
      failures++; $display("FAIL sat_pulse: got %b expected 1", bus.erro_quadro); end
    idle(1);
    checks++;
    if (bus.db_num_erros !== 8'd255) begin
      failures++; $display("FAIL sat_hold: got %0d expected 255", bus.db_num_erros); end
    checks++;
    if ({bus.posicao_1, bus.posicao_2, bus.posicao_3} !== 6'b011011) begin
      failures++; $display("FAIL sat_positions_hold: got %b expected 011011",
                           {bus.posicao_1, bus.posicao_2, bus.posicao_3}); end
  endtask

  task automatic test_reset_mid_frame();
    int e0;
    send_char(7'h23); idle(2);
    send_char(7'h32); idle(2);
    send_char(7'h32); idle(2);
    send_char(7'h32); idle(2);
    exp_q.push_back(6'b10_10_10);
    send_char(7'h2E);
    checks++;
    if ({bus.posicao_1, bus.posicao_2, bus.posicao_3} !== 6'b101010) begin
      failures++; $display("FAIL midreset_setup: got %b expected 101010",
                           {bus.posicao_1, bus.posicao_2, bus.posicao_3}); end
    idle(1);
    send_char(7'h23); idle(2);
    send_char(7'h32);
    checks++;
    if (bus.db_estado !== 4'h2) begin
      failures++; $display("FAIL midreset_in_r2: got %0h expected 2", bus.db_estado); end
    e0 = err_cnt;
    reset = 1'b0;
    #2;
    checks++;
    if ({bus.posicao_1, bus.posicao_2, bus.posicao_3} !== 6'b000000) begin
      failures++; $display("FAIL midreset_positions: got %b expected 000000",
                           {bus.posicao_1, bus.posicao_2, bus.posicao_3}); end
    checks++;
    if ({bus.erro_quadro, bus.db_estado, bus.db_num_erros} !== 13'd0) begin
      failures++; $display("FAIL midreset_state: got erro=%b estado=%0h count=%0d expected 0 0 0",
                           bus.erro_quadro, bus.db_estado, bus.db_num_erros); end
    exp_err = 0;
    idle(2);
    reset = 1'b1;
    idle(1);
    checks++;
    if ((err_cnt - e0) !== 0 || bus.db_estado !== 4'h0) begin
      failures++; $display("FAIL midreset_no_error: got pulses=%0d estado=%0h expected 0 0",
                           err_cnt - e0, bus.db_estado); end
    send_char(7'h23); idle(2);
    send_char(7'h33); idle(2);
    send_char(7'h31); idle(2);
    send_char(7'h30); idle(2);
    exp_q.push_back(6'b11_01_00);
    send_char(7'h2E);
    checks++;
    if ({bus.posicao_1, bus.posicao_2, bus.posicao_3} !== 6'b110100) begin
      failures++; $display("FAIL midreset_next_frame: got %b expected 110100",
                           {bus.posicao_1, bus.posicao_2, bus.posicao_3}); end
    idle(1);
  endtask

  // Sequence of scenarios and final report.
  initial begin
    test_reset();
    test_valid_frame();
    test_bad_digit();
    test_resync();
    test_timeout();
    test_garbage();
    test_saturation();
    test_reset_mid_frame();
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL sb_leftover: got %0d pending updates expected 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
